mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: 256x16 sync RAM, pipelined reads, sticky error, optional MMIO.
// Define MEM_CTRL_MMIO_EN to enable the LED (9'h100) and switch (9'h140) port.
module mem_ctrl #(
   parameter int    DATA_W    = 16,
   parameter int    RAM_AW    = 8,
   parameter int    READ_LAT  = 1,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mem_cmd,
   input  logic [8:0]        mem_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic [7:0]        sw,
   output logic [DATA_W-1:0] read_data,
   output logic              read_valid,
   output logic              mem_err,
   output logic [7:0]        led
);

   localparam int WORDS = 1 << RAM_AW;

   typedef enum logic [1:0] {
      MNONE  = 2'b00,
      MREAD  = 2'b01,
      MWRITE = 2'b10,
      MRSVD  = 2'b11
   } cmd_t;

   logic [DATA_W-1:0] ram [WORDS];
   logic [RAM_AW-1:0] idx;
   logic              is_rd, is_wr, is_rsv;
   logic              ram_hit, led_hit, sw_hit, mapped;
   logic              err_now;
   logic [DATA_W-1:0] rd_mux;
   logic [DATA_W-1:0] s0_data;
   logic              s0_valid;

   if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
      $error("mem_ctrl: READ_LAT must be 1 or 2");
   end

   assign idx     = mem_addr[RAM_AW-1:0];
   assign is_rd   = mem_cmd == MREAD;
   assign is_wr   = mem_cmd == MWRITE;
   assign is_rsv  = mem_cmd == MRSVD;
   assign ram_hit = ~mem_addr[8];

`ifdef MEM_CTRL_MMIO_EN
   assign led_hit = mem_addr == 9'h100;
   assign sw_hit  = mem_addr == 9'h140;
`else
   assign led_hit = 1'b0;
   assign sw_hit  = 1'b0;
`endif

   assign mapped  = ram_hit | led_hit | sw_hit;
   // Unmapped access, reserved command, or store to the read-only switch port
   assign err_now = is_rsv
                  | ((is_rd | is_wr) & ~mapped)
                  | (is_wr & sw_hit);

   // Read source select; unmapped reads return zero
   always_comb begin
      rd_mux = '0;
      if (ram_hit) begin
         rd_mux = ram[idx];
      end
`ifdef MEM_CTRL_MMIO_EN
      else if (sw_hit) begin
         rd_mux = {{(DATA_W-8){1'b0}}, sw};
      end
`endif
   end

   // RAM store port; contents survive reset
   always_ff @(posedge clk) begin
      if (is_wr && ram_hit) begin
         ram[idx] <= write_data;
      end
   end

   // Read stage 0: capture data and valid at the command edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s0_valid <= 1'b0;
         s0_data  <= '0;
      end else begin
         s0_valid <= is_rd;
         if (is_rd) begin
            s0_data <= rd_mux;
         end
      end
   end

   if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] s1_data;
      logic              s1_valid;
      // Read stage 1: extra register, holds last result between reads
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
         end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
               s1_data <= s0_data;
            end
         end
      end
      assign read_data  = s1_data;
      assign read_valid = s1_valid;
   end else begin : g_lat1
      assign read_data  = s0_data;
      assign read_valid = s0_valid;
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_err <= 1'b0;
      end else if (err_now) begin
         mem_err <= 1'b1;
      end
   end

`ifdef MEM_CTRL_MMIO_EN
   // LED register written through 9'h100
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led <= 8'h00;
      end else if (is_wr && led_hit) begin
         led <= write_data[7:0];
      end
   end
`else
   logic unused_sw;
   assign unused_sw = ^sw;
   assign led       = 8'h00;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: READ_LAT=1 and READ_LAT=2 instances on shared stimulus,
// each with its own expected-read queue drained by a monitor.
module tb_mem_ctrl;

`ifdef MEM_CTRL_MMIO_EN
   localparam bit MMIO = 1'b1;
`else
   localparam bit MMIO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  mem_cmd = 2'b00;
   logic [8:0]  mem_addr = '0;
   logic [15:0] write_data = '0;
   logic [7:0]  sw = '0;

   logic [15:0] rd1, rd2;
   logic        rv1, rv2, er1, er2;
   logic [7:0]  led1, led2;

   logic [15:0] q1[$];
   logic [15:0] q2[$];

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mem_ctrl #(.READ_LAT(1)) u1 (
      .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
      .write_data(write_data), .sw(sw), .read_data(rd1),
      .read_valid(rv1), .mem_err(er1), .led(led1)
   );

   mem_ctrl #(.READ_LAT(2)) u2 (
      .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
      .write_data(write_data), .sw(sw), .read_data(rd2),
      .read_valid(rv2), .mem_err(er2), .led(led2)
   );

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Scoreboard monitors, sampled 1 time unit after the edge
   always @(posedge clk) begin
      #1;
      if (rv1 === 1'b1) begin
         if (q1.size() == 0) begin
            n_total++;
            $display("FAIL valid_l1: unexpected pulse data %h, none expected", rd1);
         end else begin
            chk("rdata_l1", rd1, q1.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rv2 === 1'b1) begin
         if (q2.size() == 0) begin
            n_total++;
            $display("FAIL valid_l2: unexpected pulse data %h, none expected", rd2);
         end else begin
            chk("rdata_l2", rd2, q2.pop_front());
         end
      end
   end

   task automatic op(input logic [1:0] c, input logic [8:0] a,
                     input logic [15:0] d, input logic [15:0] exp);
      @(negedge clk);
      mem_cmd    = c;
      mem_addr   = a;
      write_data = d;
      if (c == 2'b01) begin
         q1.push_back(exp);
         q2.push_back(exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) op(2'b00, 9'h000, 16'h0000, 16'h0000);
   endtask

   task automatic do_reset();
      @(negedge clk);
      mem_cmd = 2'b00;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic chk_state(input string tag, input logic e,
                            input logic [7:0] l);
      chk({tag, "_err_l1"}, {15'd0, er1}, {15'd0, e});
      chk({tag, "_err_l2"}, {15'd0, er2}, {15'd0, e});
      chk({tag, "_led_l1"}, {8'd0, led1}, {8'd0, l});
      chk({tag, "_led_l2"}, {8'd0, led2}, {8'd0, l});
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // reset state
      chk("rst_rdata_l1", rd1, 16'h0000);
      chk("rst_rdata_l2", rd2, 16'h0000);
      chk("rst_valid_l1", {15'd0, rv1}, 16'h0000);
      chk("rst_valid_l2", {15'd0, rv2}, 16'h0000);
      chk_state("rst", 1'b0, 8'h00);

      // write then read-after-write
      op(2'b10, 9'h005, 16'hA5C3, 16'h0);
      op(2'b01, 9'h005, 16'h0000, 16'hA5C3);
      idle(3);
      chk_state("raw", 1'b0, 8'h00);

      // four back-to-back reads
      op(2'b10, 9'h000, 16'h1111, 16'h0);
      op(2'b10, 9'h001, 16'h2222, 16'h0);
      op(2'b10, 9'h002, 16'h3333, 16'h0);
      op(2'b10, 9'h003, 16'h4444, 16'h0);
      op(2'b01, 9'h000, 16'h0000, 16'h1111);
      op(2'b01, 9'h001, 16'h0000, 16'h2222);
      op(2'b01, 9'h002, 16'h0000, 16'h3333);
      op(2'b01, 9'h003, 16'h0000, 16'h4444);
      idle(3);
      chk("hold_rdata_l1", rd1, 16'h4444);
      chk("hold_rdata_l2", rd2, 16'h4444);

      // MMIO LED write and switch read
      sw = 8'h3C;
      op(2'b10, 9'h100, 16'h12F0, 16'h0);
      op(2'b01, 9'h140, 16'h0000, MMIO ? 16'h003C : 16'h0000);
      idle(3);
      chk_state("mmio", !MMIO, MMIO ? 8'hF0 : 8'h00);
      op(2'b10, 9'h140, 16'hFFFF, 16'h0);
      idle(1);
      chk_state("swwr", 1'b1, MMIO ? 8'hF0 : 8'h00);

      // reset clears err and led
      do_reset();
      chk_state("rst2", 1'b0, 8'h00);

      // unmapped read
      op(2'b01, 9'h1FF, 16'h0000, 16'h0000);
      idle(1);
      chk_state("unmap", 1'b1, 8'h00);
      idle(4);
      chk_state("sticky", 1'b1, 8'h00);

      // reserved command leaves RAM and led unchanged
      do_reset();
      op(2'b10, 9'h010, 16'h1234, 16'h0);
      op(2'b10, 9'h100, 16'h0055, 16'h0);
      idle(1);
      chk_state("pre11", !MMIO, MMIO ? 8'h55 : 8'h00);
      op(2'b11, 9'h010, 16'hFFFF, 16'h0);
      op(2'b11, 9'h100, 16'hFFFF, 16'h0);
      op(2'b01, 9'h010, 16'h0000, 16'h1234);
      idle(3);
      chk_state("cmd11", 1'b1, MMIO ? 8'h55 : 8'h00);

      // reset during an in-flight READ_LAT=2 read
      do_reset();
      op(2'b10, 9'h020, 16'hBEEF, 16'h0);
      op(2'b01, 9'h020, 16'h0000, 16'hBEEF);
      @(posedge clk);
      #3;
      reset = 1'b1;
      mem_cmd = 2'b00;
      q2.delete();
      @(posedge clk);
      #3;
      reset = 1'b0;
      chk("midrst_rdata_l2", rd2, 16'h0000);
      chk("midrst_rdata_l1", rd1, 16'h0000);
      idle(3);
      chk("midrst_valid_l2", {15'd0, rv2}, 16'h0000);
      op(2'b01, 9'h020, 16'h0000, 16'hBEEF);
      idle(4);

      // every expected read must have been delivered
      chk("drain_l1", 16'(q1.size()), 16'h0000);
      chk("drain_l2", 16'(q2.size()), 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
